// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and sizing helpers for the bit-serial ALU datapath blocks.
//   state_t        : control state of the serial adder (IDLE, SHIFT, DONE)
//   DEF_WIDTH      : default operand width
//   CNT_W_DEF      : bit-counter width for the default operand width
//   cnt_width()    : bit-counter width for an arbitrary operand width
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned CNT_W_DEF = $clog2(DEF_WIDTH);

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned cw;
        cw = int'($clog2(w));
        if (cw < 32'd1) begin
            cw = 32'd1;
        end
        return cw;
    endfunction

endpackage

// File: rtl/bit_adder.sv
// -----------------------------------------------------------------------------
// bit_adder
// Single combinational full-adder slice; addition counterpart of the
// bit_subtractor cell.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module bit_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial unsigned adder: captures A and B through a valid/ready handshake,
// adds one bit per clock with one full-adder slice and a registered carry, and
// presents the (WIDTH+1)-bit sum through a second valid/ready handshake.
//
// Parameters:
//   WIDTH      : operand width, 2..16
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : operands present on A, B
//   in_ready   : block accepts operands (IDLE only)
//   A, B       : unsigned operands, sampled on the capture edge only
//   out_valid  : Sum valid (DONE only)
//   out_ready  : consumer accepts Sum
//   Sum        : {carry_out, WIDTH-bit sum}
//   ovf        : signed two's-complement overflow flag
// Build option:
//   SERIAL_ADD_OVF_EN : when defined, ovf is registered on the last SHIFT edge;
//                       when undefined, ovf is tied low (port kept).
// -----------------------------------------------------------------------------
module serial_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Sum,
    output logic             ovf
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             fa_s;
    logic             fa_cout;

    bit_adder u_bit_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Sum bits enter from the MSB side, so bit 0 lands at the
                // LSB after WIDTH shifts.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered decodes of the next state, so
        // in_ready stays low while reset is held and neither depends on inputs
        // combinationally.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // On the MSB step, carry_q is the carry into the MSB and fa_cout the
    // carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == SHIFT) && (cnt_q == LAST)) begin
            ovf_d = carry_q ^ fa_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = {carry_q, res_q};

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=4). Expected sums and overflow
// come from plain integer arithmetic on the applied operands.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     Sum;
    logic           ovf;

    int n_vec = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_sum(input int unsigned a, input int unsigned b);
        return 32'(a + b);
    endfunction

    // Signed overflow: operands share a sign and the truncated sum's sign differs.
    function automatic logic [31:0] ref_ovf(input int unsigned a, input int unsigned b);
`ifdef SERIAL_ADD_OVF_EN
        int sa, sb, ss;
        sa = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
        sb = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
        ss = sa + sb;
        return ((ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)))) ? 32'd1 : 32'd0;
`else
        return 32'd0 + 32'(a & b & 0);
`endif
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input int unsigned a, input int unsigned b,
                         input int unsigned stall, input bit pulse);
        int unsigned lat;
        logic [31:0] es, eo;
        es = ref_sum(a, b);
        eo = ref_ovf(a, b);
        wait_ready();
        in_valid  = 1'b1;
        A         = W'(a);
        B         = W'(b);
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        check("in_ready_after_capture", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W);
        for (int unsigned i = 0; i < stall; i++) begin
            check("sum_hold", 32'(Sum), es);
            check("ovf_hold", 32'(ovf), eo);
            check("out_valid_hold", 32'(out_valid), 32'd1);
            check("in_ready_done", 32'(in_ready), 32'd0);
            if (pulse) begin
                in_valid = 1'b1;
                A = W'(1);
                B = W'(1);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("sum", 32'(Sum), es);
        check("ovf", 32'(ovf), eo);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_accept", 32'(out_valid), 32'd0);
        check("in_ready_after_accept", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(Sum), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_sum", 32'(Sum), 32'd0);

        // Directed cases
        do_op(9, 8, 0, 1'b0);
        do_op(15, 15, 0, 1'b0);
        do_op(0, 0, 0, 1'b0);
        do_op(7, 1, 0, 1'b0);
        do_op(3, 5, 6, 1'b1);

        // Reset during the second SHIFT cycle aborts the operation
        wait_ready();
        in_valid = 1'b1;
        A = W'(10);
        B = W'(6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(Sum), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(2, 2, 0, 1'b0);

        // Randomized operands, stall lengths and idle gaps
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_op($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
